// File: rtl/rect_plot_scheduler.sv
// rect_plot_scheduler: round-robin arbiter that sweeps one solid XDIM x YDIM
// rectangle per grant onto the vga_adapter plot port, one pixel per clock.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for any req; picks winner and latches its base/colour
//   DRAW  | raster sweep, one pixel per cycle, clipped pixels not plotted
//   DONE  | one-cycle done pulse to winner, round-robin pointer advances
module rect_plot_scheduler #(
  parameter int NREQ    = 3,
  parameter int XDIM    = 10,
  parameter int YDIM    = 10,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] x_in,
  input  logic [7*NREQ-1:0] y_in,
  input  logic [3*NREQ-1:0] colour_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic              plot,
  output logic [7:0]        vga_x,
  output logic [6:0]        vga_y,
  output logic [2:0]        vga_colour
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]    XLAST   = 4'(XDIM - 1);
  localparam logic [3:0]    YLAST   = 4'(YDIM - 1);
  localparam logic [PW-1:0] LASTREQ = PW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] winner_q, winner_d;
  logic [7:0]    xbase_q, xbase_d;
  logic [6:0]    ybase_q, ybase_d;
  logic [2:0]    col_q, col_d;
  logic [3:0]    xc_q, xc_d;
  logic [3:0]    yc_q, yc_d;

  logic          win_found;
  logic [PW-1:0] win_idx;
  int            arb_idx;

  // Round-robin pick: first set req scanning upward from ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    arb_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(ptr_q) + k) % NREQ;
      if (!win_found && req[arb_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(arb_idx);
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      xbase_q  <= '0;
      ybase_q  <= '0;
      col_q    <= '0;
      xc_q     <= '0;
      yc_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      xbase_q  <= xbase_d;
      ybase_q  <= ybase_d;
      col_q    <= col_d;
      xc_q     <= xc_d;
      yc_q     <= yc_d;
    end
  end

  // Next-state, counter update and outputs. Counters and base registers are
  // left untouched outside IDLE->DRAW and the sweep, so the pixel outputs
  // hold their last value while idle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    xbase_d  = xbase_q;
    ybase_d  = ybase_q;
    col_d    = col_q;
    xc_d     = xc_q;
    yc_d     = yc_q;

    vga_x      = xbase_q + {4'b0000, xc_q};
    vga_y      = ybase_q + {3'b000, yc_q};
    vga_colour = col_q;
    plot       = 1'b0;
    grant      = '0;
    done       = '0;
    busy       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_DRAW;
          winner_d = win_idx;
          xbase_d  = x_in[8*int'(win_idx) +: 8];
          ybase_d  = y_in[7*int'(win_idx) +: 7];
          col_d    = colour_in[3*int'(win_idx) +: 3];
          xc_d     = '0;
          yc_d     = '0;
        end
      end
      S_DRAW: begin
        busy  = 1'b1;
        grant = NREQ'(1) << winner_q;
        // Clip against the wrapped coordinate; a clipped pixel still costs a cycle.
        plot  = (int'(vga_x) < XSCREEN) && (int'(vga_y) < YSCREEN);
        if (xc_q == XLAST) begin
          if (yc_q == YLAST) begin
            state_d = S_DONE;
          end else begin
            xc_d = '0;
            yc_d = yc_q + 4'd1;
          end
        end else begin
          xc_d = xc_q + 4'd1;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        grant   = NREQ'(1) << winner_q;
        done    = NREQ'(1) << winner_q;
        ptr_d   = (winner_q == LASTREQ) ? '0 : winner_q + PW'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rect_plot_scheduler.sv
// Directed bench for rect_plot_scheduler: arbitration order, raster sweep,
// clipping, reset mid-draw and input latching.
module tb_rect_plot_scheduler;

  localparam int NREQ = 3;
  localparam int XD   = 10;
  localparam int YD   = 10;
  localparam int NPIX = XD * YD;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] x_in;
  logic [7*NREQ-1:0] y_in;
  logic [3*NREQ-1:0] colour_in;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              plot;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;

  int n_chk  = 0;
  int n_pass = 0;

  rect_plot_scheduler #(
    .NREQ(NREQ), .XDIM(XD), .YDIM(YD), .XSCREEN(160), .YSCREEN(120)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .grant(grant), .done(done), .busy(busy),
    .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic set_src(input int who, input logic [7:0] bx, input logic [6:0] by,
                         input logic [2:0] col);
    x_in[8*who +: 8]      = bx;
    y_in[7*who +: 7]      = by;
    colour_in[3*who +: 3] = col;
  endtask

  // Entered at the falling edge of the IDLE cycle in which 'who' should win.
  // Returns at the falling edge of the IDLE cycle following the done pulse.
  // drop_c: sweep cycle (1..NPIX, or NPIX+1 for the done cycle) on which req is
  // dropped, 0 for never. newx_c: sweep cycle on which x_in[who] is rewritten.
  task automatic serve(input int who, input logic [7:0] bx, input logic [6:0] by,
                       input logic [2:0] col, input int exp_plots, input int drop_c,
                       input int newx_c, input logic [7:0] newx);
    int nplot;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       ep;
    nplot = 0;
    ex = bx;
    ey = by;
    for (int c = 1; c <= NPIX; c++) begin
      @(negedge clk);
      ex = bx + 8'((c - 1) % XD);
      ey = by + 7'((c - 1) / XD);
      ep = (int'(ex) < 160) && (int'(ey) < 120);
      if (c == 1) begin
        chk("grant_first", 32'(grant), 32'(1) << who);
        chk("busy_draw", 32'(busy), 32'd1);
      end
      chk("pixel", {13'd0, plot, vga_x, vga_y, vga_colour}, {13'd0, ep, ex, ey, col});
      if (plot) nplot++;
      if (c == drop_c) req[who] = 1'b0;
      if (c == newx_c) x_in[8*who +: 8] = newx;
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(1) << who);
    chk("grant_done", 32'(grant), 32'(1) << who);
    chk("plot_done", 32'(plot), 32'd0);
    chk("hold_xy", {17'd0, vga_x, vga_y}, {17'd0, ex, ey});
    chk("plot_count", nplot, exp_plots);
    if (drop_c == NPIX + 1) req[who] = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_clear", 32'(done), 32'd0);
    chk("grant_idle", 32'(grant), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    x_in      = '0;
    y_in      = '0;
    colour_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_xyc", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single requester 0 at (30,30), colour 100.
    set_src(0, 8'd30, 7'd30, 3'b100);
    req[0] = 1'b1;
    serve(0, 8'd30, 7'd30, 3'b100, 100, NPIX + 1, 0, 8'd0);

    // Reset brings ptr back to 0; all three request together.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_src(0, 8'd0,   7'd0,   3'b001);
    set_src(1, 8'd50,  7'd20,  3'b010);
    set_src(2, 8'd100, 7'd100, 3'b101);
    req = 3'b111;
    serve(0, 8'd0,   7'd0,   3'b001, 100, NPIX + 1, 0, 8'd0);
    serve(1, 8'd50,  7'd20,  3'b010, 100, NPIX + 1, 0, 8'd0);
    serve(2, 8'd100, 7'd100, 3'b101, 100, NPIX + 1, 0, 8'd0);

    // Serve 1 alone (ptr -> 2), then 0 and 2 together: 2 wins first.
    set_src(1, 8'd5, 7'd60, 3'b011);
    req[1] = 1'b1;
    serve(1, 8'd5, 7'd60, 3'b011, 100, NPIX + 1, 0, 8'd0);
    set_src(0, 8'd10, 7'd10, 3'b110);
    set_src(2, 8'd70, 7'd80, 3'b111);
    req = 3'b101;
    serve(2, 8'd70, 7'd80, 3'b111, 100, NPIX + 1, 0, 8'd0);
    serve(0, 8'd10, 7'd10, 3'b110, 100, NPIX + 1, 0, 8'd0);

    // Clipping at the bottom-right corner: 5x5 visible.
    set_src(2, 8'd155, 7'd115, 3'b010);
    req[2] = 1'b1;
    serve(2, 8'd155, 7'd115, 3'b010, 25, NPIX + 1, 0, 8'd0);

    // Coordinate wrap: x 250..3 (mod 256), y 125..6 (mod 128).
    set_src(1, 8'd250, 7'd125, 3'b001);
    req[1] = 1'b1;
    serve(1, 8'd250, 7'd125, 3'b001, 28, NPIX + 1, 0, 8'd0);

    // Reset at sweep pixel 50, then a fresh full draw from requester 1.
    set_src(1, 8'd40, 7'd40, 3'b011);
    req[1] = 1'b1;
    repeat (50) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_plot", 32'(plot), 32'd0);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_xy", {17'd0, vga_x, vga_y}, 32'd0);
    reset = 1'b0;
    serve(1, 8'd40, 7'd40, 3'b011, 100, NPIX + 1, 0, 8'd0);

    // x_in changed mid-draw is ignored; req held two cycles past done
    // starts a second rectangle from the new x.
    set_src(0, 8'd20, 7'd40, 3'b110);
    req[0] = 1'b1;
    serve(0, 8'd20, 7'd40, 3'b110, 100, 0, 50, 8'd70);
    serve(0, 8'd70, 7'd40, 3'b110, 100, 1, 0, 8'd0);

    @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
